alu_arbiter: RTL and testbench
==============================

# alu_arbiter

- Sequencing controller in front of the shared, clocked RV32 ALU.
- Arbitrates round-robin between two requesters and issues one operation at a time. Waits out the ALU's registered result latency, then returns result and zero flag on a single response channel with a valid/ready handshake.
- Sits between the decode/execute control and the ALU instance.

## Interface
- XLEN, 32, operand/result width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  request pending
- req0_ready / req1_ready  out  1  request accepted this edge when valid&ready
- req0_srca, req0_srcb / req1_srca, req1_srcb  in  XLEN  operands
- req0_op / req1_op  in  4  ALU control code
- alu_srca, alu_srcb  out  XLEN  registered operands to ALU
- alu_ctrl  out  4  registered ALU control code
- alu_result  in  XLEN  ALU registered result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index of response
- rsp_result  out  XLEN  captured ALU result
- rsp_zero  out  1  rsp_result == 0, derived locally
- rsp_illegal  out  1  op code not a legal ALU operation

## Operation
- Legal codes:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111
  - All other codes are illegal.
- States:
  - IDLE
  - EXEC: operands on ALU
  - CAPT: ALU result valid, registered by controller
  - RESP: response held
- Arbitration, evaluated only in IDLE:
  - Only one valid: that requester is granted.
  - Both valid: the requester selected by the 1-bit priority pointer is granted.
  - reqN_ready = (state==IDLE) && grant==N. Ready is low in all other states.
- Accept (IDLE, valid&ready of N):
  - Latch srca/srcb/op into alu_srca/alu_srcb/alu_ctrl.
  - Set owner<=N.
  - Set pointer<=~N.
  - Next state is EXEC for a legal op, RESP for an illegal op.
- EXEC→CAPT unconditionally. CAPT→RESP unconditionally; rsp_result<=alu_result and rsp_zero<=(alu_result==0).
- Illegal op accept:
  - rsp_result<=0, rsp_zero<=1, rsp_illegal<=1.
  - The ALU is not used; alu_* are still loaded.
- RESP:
  - rsp_valid=1, rsp_id=owner.
  - rsp_* are stable until rsp_valid&rsp_ready.
  - After the handshake: IDLE, rsp_valid=0.
- The ALU's own zero flag is not consumed; it lags its result by a cycle.
- Between operations, alu_* hold their last value.

## Timing
- Reset (any state, including mid-operation): in-flight op is dropped with no response.
  - state IDLE, pointer 0 (req0 priority).
  - alu_srca/alu_srcb 0, alu_ctrl 0000.
  - rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, rsp_illegal 0.
  - req*_ready take their IDLE value the cycle after reset deasserts.
- Legal op, accept edge at E:
  - EXEC in cycle E+1; the ALU registers at the end of E+1.
  - CAPT in E+2.
  - rsp_valid rises in cycle E+3 (3-cycle latency).
- Illegal op: rsp_valid in cycle E+1.
- rsp_ready high on the first RESP cycle gives 4 cycles/op minimum: the IDLE cycle after RESP is required before the next accept.
- rsp_ready held low: stays in RESP indefinitely, no new accepts, requesters stall.
- A request arriving while busy waits; valid must stay asserted with operands stable until ready.
- Simultaneous valid right after reset: req0 wins, then req1 on the next IDLE. Alternation continues while both stay valid.

## Structure
- Package alu_pkg:
  - the 10 op code constants and the is_legal_op function
  - the state enum (IDLE/EXEC/CAPT/RESP)
- Sub-module rr_arb2:
  - combinational 2-way grant from valids and pointer
  - registered pointer update on accept
- The ALU is not instantiated inside; it connects at the parent level on the same clk/reset.

## Test plan
- req0 ADD 5+7, rsp_ready=1 → rsp_valid at accept+3, id 0, result 12, zero 0, illegal 0; req0_ready low for cycles E+1..E+3.
- req1 SUB 9-9 → result 0, rsp_zero 1 (correct despite ALU's lagging zero); prior result nonzero.
- Both valid continuously after reset, ops AND 0xF0&0x3C then OR → ids alternate 0,1,0,1; results 0x30 / 0xFC.
- req0 op 1111 → rsp_valid at accept+1, result 0, zero 1, illegal 1; alu_result ignored.
- rsp_ready low 5 cycles in RESP → rsp_* stable, both ready low, no new accept; ready high → IDLE next cycle.
- Reset asserted during EXEC → next cycle rsp_valid 0, pointer 0, no response for that op; a fresh req0 ADD 1+1 then returns 2 at accept+3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing controller: operand width,
// legal ALU control codes and the controller state encoding.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the valids and a
// one-bit priority pointer that moves past the winner on every accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  logic ptr_q, ptr_d;

  // With a single requester the pointer is irrelevant; it only breaks ties.
  always_comb begin
    grant_valid_o = |valid_i;
    if (valid_i == 2'b11) grant_o = ptr_q;
    else                  grant_o = valid_i[1];
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = ~grant_o;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Sequencing controller in front of the shared registered ALU: arbitrates
// two requesters, issues one op, waits out ALU latency, returns a response.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_srca,
  input  logic [XLEN-1:0] req0_srcb,
  input  logic [3:0]      req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_srca,
  input  logic [XLEN-1:0] req1_srcb,
  input  logic [3:0]      req1_op,
  output logic [XLEN-1:0] alu_srca,
  output logic [XLEN-1:0] alu_srcb,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero,
  output logic            rsp_illegal,
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the sender holds valid and payload stable until that edge.

  state_e          state_q, state_d;
  logic            grant, grant_valid, accept;
  logic [3:0]      sel_op;
  logic            sel_legal;
  logic [XLEN-1:0] alu_srca_q, alu_srcb_q, rsp_result_q;
  logic [3:0]      alu_ctrl_q;
  logic            owner_q, rsp_zero_q, rsp_illegal_q;

  rr_arb2 u_arb (
    .clk           (clk),
    .reset         (reset),
    .valid_i       ({req1_valid, req0_valid}),
    .accept_i      (accept),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  assign sel_op    = grant ? req1_op : req0_op;
  assign sel_legal = is_legal_op(sel_op);
  assign accept    = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = sel_legal ? ST_EXEC : ST_RESP;
      ST_EXEC: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is masked during reset so nothing is offered before IDLE is real.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      ST_IDLE: if (!reset && grant_valid) begin
        req0_ready = ~grant;
        req1_ready = grant;
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_srca_q    <= '0;
      alu_srcb_q    <= '0;
      alu_ctrl_q    <= '0;
      owner_q       <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        alu_srca_q <= grant ? req1_srca : req0_srca;
        alu_srcb_q <= grant ? req1_srcb : req0_srcb;
        alu_ctrl_q <= sel_op;
        owner_q    <= grant;
        if (!sel_legal) begin
          rsp_result_q  <= '0;
          rsp_zero_q    <= 1'b1;
          rsp_illegal_q <= 1'b1;
        end else begin
          rsp_illegal_q <= 1'b0;
        end
      end
      // The ALU's own zero flag lags its result, so zero is derived here.
      if (state_q == ST_CAPT) begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= (alu_result == '0);
      end
    end
  end

  assign alu_srca    = alu_srca_q;
  assign alu_srcb    = alu_srcb_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign rsp_id      = owner_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_illegal = rsp_illegal_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reference registered ALU, a transaction-level model
// of the controller compared every cycle, directed cases and random traffic.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_srca, alu_srcb, alu_result, rsp_result;
  logic [3:0]  alu_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  logic [3:0] legal_tab [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_op(req1_op),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
    .dbg_state(dbg_state)
  );

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return 32'($signed(a) >>> b[4:0]);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_legal(logic [3:0] op);
    return op inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference ALU with one cycle of registered latency.
  always @(posedge clk) begin
    if (reset) alu_result <= 32'd0;
    else       alu_result <= alu_fn(alu_srca, alu_srcb, alu_ctrl);
  end

  // Transaction-level model: busy flag, cycle at which the response shows up.
  bit          m_busy, m_ptr, m_id, m_ill;
  int          m_rsp_cyc;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_ctrl;
  logic [33:0] exp_q[$];

  always @(posedge clk) begin
    bit g, any;
    any = req0_valid || req1_valid;
    g   = (req0_valid && req1_valid) ? m_ptr : req1_valid;
    if (reset) begin
      m_busy = 0; m_ptr = 0; m_id = 0;
      m_a = 0; m_b = 0; m_ctrl = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (any) begin
        m_a    = g ? req1_srca : req0_srca;
        m_b    = g ? req1_srcb : req0_srcb;
        m_ctrl = g ? req1_op : req0_op;
        m_id   = g;
        m_ill  = !is_legal(m_ctrl);
        m_res  = m_ill ? 32'd0 : alu_fn(m_a, m_b, m_ctrl);
        m_rsp_cyc = cyc + (m_ill ? 1 : 3);
        m_ptr  = !g;
        m_busy = 1;
        exp_q.push_back({m_id, m_ill, m_res});
      end
    end else if (cyc >= m_rsp_cyc && rsp_ready) begin
      m_busy = 0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit g, any, e0, e1, ev;
    logic [33:0] e;
    if (chk_en) begin
      any = req0_valid || req1_valid;
      g   = (req0_valid && req1_valid) ? m_ptr : req1_valid;
      e0  = !reset && !m_busy && any && !g;
      e1  = !reset && !m_busy && any && g;
      ev  = m_busy && (cyc >= m_rsp_cyc);
      check("req0_ready", 32'(req0_ready), 32'(e0));
      check("req1_ready", 32'(req1_ready), 32'(e1));
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      check("alu_srca", alu_srca, m_a);
      check("alu_srcb", alu_srcb, m_b);
      check("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
      if (ev) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_result", rsp_result, m_res);
        check("rsp_zero", 32'(rsp_zero), 32'(m_res == 32'd0));
        check("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
      end
      if (rsp_valid && rsp_ready && !reset) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_id", 32'(rsp_id), 32'(e[33]));
          check("sb_illegal", 32'(rsp_illegal), 32'(e[32]));
          check("sb_result", rsp_result, e[31:0]);
        end
      end
    end
  end

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    if (id == 0) begin req0_srca = a; req0_srcb = b; req0_op = op; req0_valid = 1; end
    else         begin req1_srca = a; req1_srcb = b; req1_op = op; req1_valid = 1; end
  endtask

  task automatic wait_accept(input int id, output int acc);
    bit got = 0;
    acc = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin got = 1; acc = cyc; end
      @(posedge clk); #1;
    end
    if (id == 0) req0_valid = 0; else req1_valid = 0;
    if (!got) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output logic [31:0] r, output logic z, output logic il,
                          output logic id, output int at);
    bit got = 0;
    r = 'x; z = 'x; il = 'x; id = 'x; at = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1; r = rsp_result; z = rsp_zero; il = rsp_illegal; id = rsp_id; at = cyc;
      end
    end
    @(posedge clk); #1;
    if (!got) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input int rid, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, output logic [31:0] r, output logic z,
                        output logic il, output logic id, output int lat);
    int acc, at;
    set_req(rid, a, b, op);
    wait_accept(rid, acc);
    wait_rsp(r, z, il, id, at);
    lat = at - acc;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  function automatic logic [3:0] rand_op();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
    return legal_tab[$urandom_range(0, 9)];
  endfunction

  initial begin
    logic [31:0] r;
    logic        z, il, id;
    int          lat, acc, at, n;
    logic [31:0] res_seen [4];
    logic        id_seen [4];
    bit          a0, a1;

    reset = 1; rsp_ready = 1;
    req0_valid = 0; req0_srca = 0; req0_srcb = 0; req0_op = 0;
    req1_valid = 0; req1_srca = 0; req1_srcb = 0; req1_op = 0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_alu_srca", alu_srca, 32'd0);
    @(posedge clk); #1 reset = 0;

    // ADD 5+7 from req0
    run_op(0, 32'd5, 32'd7, 4'b0000, r, z, il, id, lat);
    check("add_lat", lat, 3);
    check("add_result", r, 32'd12);
    check("add_zero", 32'(z), 32'd0);
    check("add_illegal", 32'(il), 32'd0);
    check("add_id", 32'(id), 32'd0);

    // SUB 9-9 from req1, prior result nonzero
    run_op(1, 32'd9, 32'd9, 4'b1000, r, z, il, id, lat);
    check("sub_lat", lat, 3);
    check("sub_result", r, 32'd0);
    check("sub_zero", 32'(z), 32'd1);
    check("sub_id", 32'(id), 32'd1);

    // illegal op
    run_op(0, 32'd3, 32'd4, 4'b1111, r, z, il, id, lat);
    check("ill_lat", lat, 1);
    check("ill_result", r, 32'd0);
    check("ill_zero", 32'(z), 32'd1);
    check("ill_illegal", 32'(il), 32'd1);

    // both valid from reset: alternation
    set_req(0, 32'hF0, 32'h3C, 4'b0111);
    set_req(1, 32'hF0, 32'h3C, 4'b0110);
    do_reset();
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) begin id_seen[n] = rsp_id; res_seen[n] = rsp_result; n++; end
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    check("alt_count", n, 4);
    for (int i = 0; i < n; i++) begin
      check("alt_id", 32'(id_seen[i]), 32'(i % 2));
      check("alt_result", res_seen[i], (i % 2 == 0) ? 32'h30 : 32'hFC);
    end
    repeat (6) @(posedge clk); #1;

    // response stall
    rsp_ready = 0;
    run_op(0, 32'h55, 32'h0F, 4'b0100, r, z, il, id, lat);
    check("stall_result", r, 32'h5A);
    set_req(1, 32'd2, 32'd3, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_hold", rsp_result, 32'h5A);
      check("stall_ready0", 32'(req0_ready), 32'd0);
      check("stall_ready1", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(negedge clk);
    check("stall_release_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_idle_ready1", 32'(req1_ready), 32'd1);
    check("stall_idle_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 req1_valid = 0;
    repeat (6) @(posedge clk); #1;

    // reset during EXEC drops the op; pointer returns to req0
    set_req(1, 32'd20, 32'd22, 4'b0000);
    wait_accept(1, acc);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_exec_no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    set_req(0, 32'd1, 32'd1, 4'b0000);
    set_req(1, 32'd4, 32'd4, 4'b1000);
    @(negedge clk);
    check("rst_ptr_ready0", 32'(req0_ready), 32'd1);
    check("rst_ptr_ready1", 32'(req1_ready), 32'd0);
    acc = cyc;
    @(posedge clk); #1 req0_valid = 0;
    wait_rsp(r, z, il, id, at);
    check("rst_add_lat", at - acc, 3);
    check("rst_add_result", r, 32'd2);
    check("rst_add_id", 32'(id), 32'd0);
    wait_accept(1, acc);
    repeat (6) @(posedge clk); #1;

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_srca = $urandom; req0_srcb = $urandom; req0_op = rand_op();
        if ($urandom_range(0, 5) == 0) req0_srcb = req0_srca;
      end
      if (a1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_srca = $urandom; req1_srcb = $urandom; req1_op = rand_op();
        if ($urandom_range(0, 5) == 0) req1_srcb = req1_srca;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge clk); #1;
    if (a0) req0_valid = 0;
    if (a1) req1_valid = 0;
    rsp_ready = 1;
    // let any still-pending request through, then drain
    for (int i = 0; i < 40 && (req0_valid || req1_valid); i++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0) req0_valid = 0;
      if (a1) req1_valid = 0;
    end
    repeat (10) @(posedge clk); #1;
    check("sb_drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
